mp_subtractor: RTL
==================

# mp_subtractor

Multi-cycle, multi-precision subtractor that computes iOpA − iOpB one ADDER_WIDTH-bit limb per clock, LSB limb first, with a registered borrow chain. It is the inverse companion of the multi-precision adder in the fast-arithmetic datapath and uses the same start/done handshake, so either unit can sit behind the same sequencer. The result carries a borrow-out bit, so oRes equals ({1'b0,iOpA} − {1'b0,iOpB}) mod 2^(OPERAND_WIDTH+1).

## Interface
- OPERAND_WIDTH, 128: operand width in bits; must be an integer multiple of ADDER_WIDTH.
- ADDER_WIDTH, 32: limb width processed per cycle. NUM_LIMBS = OPERAND_WIDTH/ADDER_WIDTH.
- iClk  in  1  sole clock, all state on rising edge.
- iRst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- iStart  in  1  start request, sampled only in IDLE.
- iOpA  in  OPERAND_WIDTH  minuend, captured on the accepting edge.
- iOpB  in  OPERAND_WIDTH  subtrahend, captured on the accepting edge.
- oRes  out  OPERAND_WIDTH+1  bit OPERAND_WIDTH = borrow-out (1 iff A < B); low bits = A − B mod 2^OPERAND_WIDTH.
- oDone  out  1  single-cycle pulse, oRes valid.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if iStart = 1, latch iOpA/iOpB into shift registers, clear limb counter, set carry register to 1 (subtraction as A + ~B + 1), go to RUN. Otherwise stay.
- RUN: each cycle, take the low limb a, b; compute {c, d} = a + ~b + carry; shift d into the MSB end of the result register; shift the operand registers right by ADDER_WIDTH; carry ← c; increment the counter. After NUM_LIMBS limbs, set oRes[OPERAND_WIDTH] = ~carry (borrow), go to DONE.
- DONE: oDone = 1 for this cycle only; unconditionally go to IDLE. iStart in DONE is ignored.
- iStart during RUN/DONE is ignored; the operands in flight are unaffected by changes to iOpA/iOpB after capture.
- oRes holds its last value from DONE until the next completion, and is not cleared on a new start. It updates only on the DONE-entry edge, so intermediate limbs never appear on oRes; the shift register is internal.
- Reset (iRst = 0, any time, including mid-RUN): state ← IDLE, oDone ← 0, oRes ← 0, counter/carry/operand registers ← 0. No done pulse for the aborted operation.

## Timing
- Edge k: iStart = 1 in IDLE accepted.
- Edges k+1 … k+NUM_LIMBS: limbs 0 … NUM_LIMBS−1 processed. The state becomes DONE after edge k+NUM_LIMBS, with oRes valid.
- oDone high during the cycle after edge k+NUM_LIMBS; low again after edge k+NUM_LIMBS+1 (back in IDLE).
- Latency from the accepting edge to oDone high = NUM_LIMBS edges (4 for defaults); the minimum start-to-start period is NUM_LIMBS+2 cycles.
- Reset values: oRes = 0, oDone = 0.
- Critical path: one ADDER_WIDTH+1-bit adder plus the carry register; no cross-limb combinational ripple.

## Structure
- Shared package mp_arith_pkg: FSM state enum (IDLE/RUN/DONE) and a limb-count function (width ÷ limb width). The mp_adder uses the same package.
- One natural sub-module: limb_subtractor, combinational, ADDER_WIDTH wide: inputs a, b, cin; outputs diff and cout, where {cout, diff} = a + ~b + cin.
- Top: FSM, counter of width $clog2(NUM_LIMBS+1), operand and result shift registers, carry register.

## Test plan
- A = efefefef_cdcdcdcd_abababab_90909090, B = 12121212_34343434_56565656_78787878 → oRes = 0_dddddddd_99999999_55555555_18181818, oDone exactly 4 edges after the start edge.
- A = 0, B = 1 → oRes = 1_ffffffff_ffffffff_ffffffff_ffffffff; the borrow ripples through every limb.
- A = 0x1_00000000 (2^32), B = 1 → oRes = 0_00000000_00000000_00000000_ffffffff; a single cross-limb borrow.
- A = B = 12121212_34343434_56565656_78787878 → oRes = 0. Then hold iStart high continuously with varying operands: completions every 6 cycles, each result matches the operands captured at its own accept edge.
- Assert iRst = 0 for 1 cycle at the second RUN cycle → oRes = 0, oDone = 0 immediately and no pulse follows; a subsequent start with A = 5, B = 7 → oRes = 1_ffffffff_ffffffff_ffffffff_fffffffe.

Source files
------------

// File: rtl/mp_arith_pkg.sv
// Shared definitions for the multi-precision adder/subtractor pair:
// sequencer state encoding and limb-count helper.
package mp_arith_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int limbCount(input int width, input int limbWidth);
      return width / limbWidth;
   endfunction

endpackage

// File: rtl/mp_subtractor_if.sv
// Start/done handshake and operand/result bus shared by the multi-precision units.
interface mp_subtractor_if #(
   parameter int OPERAND_WIDTH = 128
);
   logic                     iStart;
   logic [OPERAND_WIDTH-1:0] iOpA;
   logic [OPERAND_WIDTH-1:0] iOpB;
   logic [OPERAND_WIDTH:0]   oRes;
   logic                     oDone;

   modport master (
      output iStart, iOpA, iOpB,
      input  oRes, oDone
   );

   modport slave (
      input  iStart, iOpA, iOpB,
      output oRes, oDone
   );
endinterface

// File: rtl/mp_subtractor_limb.sv
// One limb of the subtract chain: {cout, diff} = a + ~b + cin.
module limb_subtractor #(
   parameter int ADDER_WIDTH = 32
) (
   input  logic [ADDER_WIDTH-1:0] a,
   input  logic [ADDER_WIDTH-1:0] b,
   input  logic                   cin,
   output logic [ADDER_WIDTH-1:0] diff,
   output logic                   cout
);
   assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + (ADDER_WIDTH + 1)'(cin);
endmodule

// File: rtl/mp_subtractor.sv
// Multi-cycle multi-precision subtractor: one limb per clock, LSB first,
// registered borrow chain, oRes = {borrow, A - B}. Needs at least two limbs.
module mp_subtractor
   import mp_arith_pkg::*;
#(
   parameter int OPERAND_WIDTH = 128,
   parameter int ADDER_WIDTH   = 32
) (
   input  logic          iClk,
   input  logic          iRst,
   mp_subtractor_if.slave bus
);
   localparam int NUM_LIMBS = limbCount(OPERAND_WIDTH, ADDER_WIDTH);
   localparam int CNT_W     = $clog2(NUM_LIMBS + 1);
   localparam logic [CNT_W-1:0] LAST_LIMB = CNT_W'(NUM_LIMBS - 1);

   state_e                               state;
   logic [CNT_W-1:0]                     limbCnt;
   logic                                 carry;
   logic [OPERAND_WIDTH-1:0]             opA;
   logic [OPERAND_WIDTH-1:0]             opB;
   logic [OPERAND_WIDTH-ADDER_WIDTH-1:0] resSh;
   logic [OPERAND_WIDTH:0]               res;
   logic                                 done;

   logic [ADDER_WIDTH-1:0]               diff;
   logic                                 cout;
   logic [OPERAND_WIDTH-1:0]             resFull;

   limb_subtractor #(
      .ADDER_WIDTH(ADDER_WIDTH)
   ) uLimb (
      .a   (opA[ADDER_WIDTH-1:0]),
      .b   (opB[ADDER_WIDTH-1:0]),
      .cin (carry),
      .diff(diff),
      .cout(cout)
   );

   // The shift register holds every finished limb except the current one,
   // so the full result is the new limb on top of it.
   assign resFull = {diff, resSh};

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         state   <= IDLE;
         limbCnt <= '0;
         carry   <= 1'b0;
         opA     <= '0;
         opB     <= '0;
         resSh   <= '0;
         res     <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.iStart) begin
                  opA     <= bus.iOpA;
                  opB     <= bus.iOpB;
                  limbCnt <= '0;
                  carry   <= 1'b1;
                  state   <= RUN;
               end
            end
            RUN: begin
               resSh   <= resFull[OPERAND_WIDTH-1:ADDER_WIDTH];
               opA     <= opA >> ADDER_WIDTH;
               opB     <= opB >> ADDER_WIDTH;
               carry   <= cout;
               limbCnt <= limbCnt + CNT_W'(1);
               if (limbCnt == LAST_LIMB) begin
                  res   <= {~cout, resFull};
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.oRes  = res;
   assign bus.oDone = done;
endmodule
